sm83_irq_ctl: RTL and testbench
===============================

// Module: sm83_irq_ctl
// PURPOSE
//  Interrupt sequencer for the sm83 core. Owns IME, the EI delay and the HALT state, and
//  arbitrates the NUM_IRQS request lines into one dispatch. The control unit only sees
//  "dispatch in progress", the M-cycle index, the vector and a one-clk iack pulse.
//  Sits beside sm83_control. Uses the same M-cycle strobes as the instruction sequencer.
// PARAMETERS
//  NUM_IRQS   8        number of request lines; index 0 = highest priority
//  ADR_WIDTH  16       vector width
//  VEC_BASE   16'h0040 vector of irq[0]
//  VEC_SHIFT  3        vector(i) = VEC_BASE + (i << VEC_SHIFT)
// PORTS
//  clk        in   1          core clock; all state updates on posedge
//  reset      in   1          synchronous, active-high
//  mcyc_end   in   1          high on last clk (T4) of every M-cycle
//  insn_end   in   1          high with mcyc_end on the last M-cycle of an instruction
//  op_ei      in   1          EI decoded; sampled only when insn_end & mcyc_end
//  op_di      in   1          DI decoded; same qualification
//  op_reti    in   1          RETI decoded; same qualification
//  op_halt    in   1          HALT decoded; same qualification
//  irq        in   NUM_IRQS   pending requests, already masked by IE (level)
//  iack       out  NUM_IRQS   one-hot, one clk, acknowledges serviced request
//  dispatch   out  1          high during the dispatch M-cycles D1..D5
//  disp_m     out  3          current dispatch M-cycle: 0..4 = D1..D5; 0 when idle
//  vector     out  ADR_WIDTH  jump target; valid while vec_valid
//  vec_valid  out  1          high during D5
//  ime        out  1          interrupt master enable
//  halted     out  1          core halted; control must stall fetch
//  halt_bug   out  1          one-clk pulse: next fetch must not increment PC
// BEHAVIOUR
//  Reset
//   - State IDLE. ime=0, ei_pend=0, halted=0.
//   - iack=0, dispatch=0, disp_m=0, vector=0, vec_valid=0, halt_bug=0.
//   - Reset wins over all other inputs in the same clk, including mid-dispatch.
//     Reset mid-dispatch aborts the dispatch and emits no iack.
//  Boundary event
//   - B = mcyc_end & insn_end & state==IDLE & !halted.
//   - op_* inputs are ignored outside B.
//  IME
//   - At B, priority order: DI > RETI > EI.
//     - DI: ime=0, ei_pend=0.
//     - RETI: ime=1 immediately.
//     - EI: ei_pend=1.
//   - At a B where ei_pend was already 1 and no DI is present: ime=1, ei_pend=0.
//     Net effect: EI takes effect after the following instruction.
//   - EI;EI keeps ei_pend set and does not shorten the delay.
//  Dispatch start
//   - At B, if the pre-update ime==1 and |irq: state D1, ime=0, ei_pend=0.
//   - The op_* decode of that boundary is discarded.
//   - The ime value set by RETI at boundary N is first seen at boundary N+1.
//  Sequence
//   - Advance D1 -> D2 -> D3 -> D4 -> D5 -> IDLE, one step per mcyc_end.
//   - Exactly 5 M-cycles.
//   - dispatch=1 and disp_m=0..4 while in D1..D5.
//  Priority sample
//   - Taken on the clk of mcyc_end in D4, i.e. after the PC-high push.
//   - i = lowest set index of irq.
//     - iack[i]=1 for that clk only.
//     - vector = VEC_BASE + (i << VEC_SHIFT), registered and held through D5.
//   - If irq==0 at the sample, no iack and vector=0.
//   - A request dropped between start and sample is not serviced.
//  HALT
//   - At B with op_halt and ime==0 and |irq: halted stays 0; halt_bug pulses for 1 clk.
//   - Otherwise op_halt at B sets halted=1.
//   - While halted, a clk with |irq clears halted on the next posedge.
//     mcyc_end is not required to leave HALT.
//   - After wake:
//     - If ime=1, dispatch starts at the next mcyc_end, bypassing the insn_end requirement.
//     - Otherwise execution resumes with no dispatch.
//  Misc
//   - vector is held at its last value when idle, cleared only by reset.
//   - iack is never asserted outside D4, and never more than one bit at a time.
// TESTING
//  T1 ime=1, irq=8'h05 at B -> D1..D5 over 5 M-cycles; iack=8'h01 at D4 end; vector=16'h0040 in D5; ime=0.
//  T2 EI at boundary N, irq=8'h10 held -> no dispatch at N+1 boundary; dispatch starts at N+2 with vector=16'h0060.
//  T3 dispatch started with irq=8'h02, irq dropped to 0 in D2 -> no iack; vector=16'h0000 in D5.
//  T4 irq changes 8'h08 -> 8'h0A during D3 -> iack=8'h02 and vector=16'h0048.
//  T5 HALT with ime=0, irq=0; then irq=8'h04 -> halted 1 then 0, no dispatch. Repeat with irq=8'h04 already pending at HALT -> halt_bug one-clk pulse.
//  T6 reset asserted in D3 -> next clk: IDLE, dispatch=0, ime=0, iack never pulses.

Source files
------------

// File: rtl/sm83_irq_ctl.sv
// sm83_irq_ctl: interrupt sequencer for the sm83 core.
// Owns IME, the one-instruction EI delay and the HALT state, and turns the
// IE-masked request lines into a five M-cycle dispatch with a priority
// sample at the end of D4 (after the PC-high push).
module sm83_irq_ctl #(
    parameter int                   NUM_IRQS  = 8,
    parameter int                   ADR_WIDTH = 16,
    parameter logic [ADR_WIDTH-1:0] VEC_BASE  = 16'h0040,
    parameter int                   VEC_SHIFT = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mcyc_end,
    input  logic                 insn_end,
    input  logic                 op_ei,
    input  logic                 op_di,
    input  logic                 op_reti,
    input  logic                 op_halt,
    input  logic [NUM_IRQS-1:0]  irq,
    output logic [NUM_IRQS-1:0]  iack,
    output logic                 dispatch,
    output logic [2:0]           disp_m,
    output logic [ADR_WIDTH-1:0] vector,
    output logic                 vec_valid,
    output logic                 ime,
    output logic                 halted,
    output logic                 halt_bug
);

    localparam int IDX_W = (NUM_IRQS > 1) ? $clog2(NUM_IRQS) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_D1   = 3'd1,
        S_D2   = 3'd2,
        S_D3   = 3'd3,
        S_D4   = 3'd4,
        S_D5   = 3'd5
    } state_t;

    // Index of the highest-priority (lowest-numbered) pending request.
    function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_IRQS-1:0] v);
        lowest_idx = '0;
        for (int i = NUM_IRQS - 1; i >= 0; i--) begin
            if (v[i]) begin
                lowest_idx = IDX_W'(i);
            end else begin
                lowest_idx = lowest_idx;
            end
        end
    endfunction

    state_t                 state_r, state_s;
    logic                   ime_r, ime_s;
    logic                   ei_pend_r, ei_pend_s;
    logic                   halted_r, halted_s;
    logic                   wake_r, wake_s;      // woke from HALT with IME set
    logic                   halt_bug_r, halt_bug_s;
    logic [ADR_WIDTH-1:0]   vector_r, vector_s;
    logic                   dispatch_r;
    logic [2:0]             disp_m_r;
    logic                   vec_valid_r;
    logic                   boundary_s;
    logic                   start_s;
    logic                   any_irq_s;
    logic [NUM_IRQS-1:0]    iack_s;

    // Next-state logic: halt wake, dispatch sequencing and boundary decode.
    always_comb begin
        state_s    = state_r;
        ime_s      = ime_r;
        ei_pend_s  = ei_pend_r;
        halted_s   = halted_r;
        wake_s     = wake_r;
        halt_bug_s = 1'b0;
        vector_s   = vector_r;
        any_irq_s  = |irq;
        boundary_s = mcyc_end & insn_end & (state_r == S_IDLE) & ~halted_r;
        // After a wake with IME set the insn_end qualification is bypassed.
        start_s    = (state_r == S_IDLE) & ~halted_r & mcyc_end &
                     (insn_end | wake_r) & ime_r & any_irq_s;

        if (halted_r) begin
            if (any_irq_s) begin
                halted_s = 1'b0;
                wake_s   = ime_r;
            end else begin
                halted_s = 1'b1;
            end
        end else if (state_r != S_IDLE) begin
            if (mcyc_end) begin
                case (state_r)
                    S_D1: state_s = S_D2;
                    S_D2: state_s = S_D3;
                    S_D3: state_s = S_D4;
                    S_D4: begin
                        state_s = S_D5;
                        if (any_irq_s) begin
                            vector_s = VEC_BASE + (ADR_WIDTH'(lowest_idx(irq)) << VEC_SHIFT);
                        end else begin
                            vector_s = '0;
                        end
                    end
                    S_D5:    state_s = S_IDLE;
                    default: state_s = S_IDLE;
                endcase
            end else begin
                state_s = state_r;
            end
        end else if (mcyc_end) begin
            wake_s = 1'b0;
            if (start_s) begin
                // Dispatch wins; this boundary's op decode is discarded.
                state_s   = S_D1;
                ime_s     = 1'b0;
                ei_pend_s = 1'b0;
            end else if (boundary_s) begin
                if (op_di) begin
                    ime_s     = 1'b0;
                    ei_pend_s = 1'b0;
                end else begin
                    if (op_reti | ei_pend_r) begin
                        ime_s = 1'b1;
                    end else begin
                        ime_s = ime_r;
                    end
                    ei_pend_s = op_ei & ~op_reti;
                end
                if (op_halt) begin
                    if (~ime_r & any_irq_s) begin
                        halt_bug_s = 1'b1;
                    end else begin
                        halted_s = 1'b1;
                    end
                end else begin
                    halted_s = 1'b0;
                end
            end else begin
                state_s = state_r;
            end
        end else begin
            state_s = state_r;
        end
    end

    // Acknowledge is only meaningful on the sampling clk of D4; reset suppresses it.
    always_comb begin
        iack_s = '0;
        if ((state_r == S_D4) & mcyc_end & ~reset) begin
            iack_s = irq & (~irq + NUM_IRQS'(1));
        end else begin
            iack_s = '0;
        end
    end

    // State and registered outputs, synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= S_IDLE;
            ime_r       <= 1'b0;
            ei_pend_r   <= 1'b0;
            halted_r    <= 1'b0;
            wake_r      <= 1'b0;
            halt_bug_r  <= 1'b0;
            vector_r    <= '0;
            dispatch_r  <= 1'b0;
            disp_m_r    <= 3'd0;
            vec_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            ime_r       <= ime_s;
            ei_pend_r   <= ei_pend_s;
            halted_r    <= halted_s;
            wake_r      <= wake_s;
            halt_bug_r  <= halt_bug_s;
            vector_r    <= vector_s;
            dispatch_r  <= (state_s != S_IDLE);
            disp_m_r    <= (state_s == S_IDLE) ? 3'd0 : (3'(state_s) - 3'd1);
            vec_valid_r <= (state_s == S_D5);
        end
    end

    assign iack      = iack_s;
    assign dispatch  = dispatch_r;
    assign disp_m    = disp_m_r;
    assign vector    = vector_r;
    assign vec_valid = vec_valid_r;
    assign ime       = ime_r;
    assign halted    = halted_r;
    assign halt_bug  = halt_bug_r;

endmodule

// File: tb/tb_sm83_irq_ctl.sv
// Testbench for sm83_irq_ctl: directed vector table, hand-written corner
// sequences and randomized traffic, all compared against a behavioural model.
module tb_sm83_irq_ctl;

    logic        clk = 1'b0;
    logic        reset, mcyc_end, insn_end, op_ei, op_di, op_reti, op_halt;
    logic [7:0]  irq;
    logic [7:0]  iack;
    logic        dispatch, vec_valid, ime, halted, halt_bug;
    logic [2:0]  disp_m;
    logic [15:0] vector;

    int n_tests = 0;
    int n_fail  = 0;
    bit mchk    = 1'b0;

    sm83_irq_ctl dut (
        .clk(clk), .reset(reset), .mcyc_end(mcyc_end), .insn_end(insn_end),
        .op_ei(op_ei), .op_di(op_di), .op_reti(op_reti), .op_halt(op_halt),
        .irq(irq), .iack(iack), .dispatch(dispatch), .disp_m(disp_m),
        .vector(vector), .vec_valid(vec_valid), .ime(ime), .halted(halted),
        .halt_bug(halt_bug)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // m_cnt: 0 = not dispatching, 1..5 = dispatch M-cycle number.
    int          m_cnt  = 0;
    bit          m_ime  = 0, m_pend = 0, m_halt = 0, m_wake = 0, m_bug = 0;
    logic [15:0] m_vec  = 16'h0000;

    function automatic int first_set(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] model_out();
        logic [7:0] ia;
        int k;
        ia = 8'h00;
        k  = first_set(irq);
        if (m_cnt == 4 && mcyc_end && !reset && k >= 0) ia[k] = 1'b1;
        return {(m_cnt != 0), (m_cnt != 0) ? 3'(m_cnt - 1) : 3'd0, ia,
                (m_cnt == 5), m_ime, m_halt, m_bug, m_vec};
    endfunction

    // Model advances on every active edge from the same inputs the DUT sees.
    always @(posedge clk) begin
        int  k;
        bit  pre;
        k = first_set(irq);
        if (reset) begin
            m_cnt = 0; m_ime = 0; m_pend = 0; m_halt = 0; m_wake = 0; m_bug = 0;
            m_vec = 16'h0000;
        end else begin
            m_bug = 0;
            if (m_halt) begin
                if (k >= 0) begin m_halt = 0; m_wake = m_ime; end
            end else if (m_cnt != 0) begin
                if (mcyc_end) begin
                    if (m_cnt == 4) m_vec = (k >= 0) ? 16'h0040 + 16'(k * 8) : 16'h0000;
                    m_cnt = (m_cnt == 5) ? 0 : m_cnt + 1;
                end
            end else if (mcyc_end) begin
                pre = m_ime;
                if (pre && k >= 0 && (insn_end || m_wake)) begin
                    m_cnt = 1; m_ime = 0; m_pend = 0;
                end else if (insn_end) begin
                    if (op_di) begin
                        m_ime = 0; m_pend = 0;
                    end else begin
                        if (op_reti || m_pend) m_ime = 1;
                        m_pend = op_ei && !op_reti;
                    end
                    if (op_halt) begin
                        if (!pre && k >= 0) m_bug = 1;
                        else m_halt = 1;
                    end
                end
                m_wake = 0;
            end
        end
    end

    function automatic logic [31:0] dut_out();
        return {dispatch, disp_m, iack, vec_valid, ime, halted, halt_bug, vector};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (mchk) chk("model", dut_out(), model_out());
    end

    // One clk of stimulus; returns at the negedge so callers can sample.
    task automatic cyc(input bit rs, input bit me, input bit ie, input bit ei,
                       input bit di, input bit rt, input bit hl, input logic [7:0] iv);
        @(posedge clk);
        #1;
        reset = rs; mcyc_end = me; insn_end = ie; op_ei = ei; op_di = di;
        op_reti = rt; op_halt = hl; irq = iv;
        @(negedge clk);
    endtask

    // ---------------- directed table ----------------
    typedef struct packed {
        logic       rs, me, ie, ei, di, rt, hl;
        logic [7:0] iv;
        logic       e_disp;
        logic [2:0] e_dm;
        logic [7:0] e_iack;
        logic       e_vv, e_ime, e_halt, e_bug;
        logic [15:0] e_vec;
    } vec_t;

    vec_t tbl [16];

    initial begin
        // T1: RETI then irq 05 -> dispatch, iack 01, vector 0040.
        tbl[0]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,8'h00, 1'b0,3'd0,8'h00,1'b0,1'b0,1'b0,1'b0,16'h0000};
        tbl[1]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,8'h05, 1'b0,3'd0,8'h00,1'b0,1'b1,1'b0,1'b0,16'h0000};
        tbl[2]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,8'h05, 1'b1,3'd0,8'h00,1'b0,1'b0,1'b0,1'b0,16'h0000};
        tbl[3]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,8'h05, 1'b1,3'd1,8'h00,1'b0,1'b0,1'b0,1'b0,16'h0000};
        tbl[4]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,8'h05, 1'b1,3'd2,8'h00,1'b0,1'b0,1'b0,1'b0,16'h0000};
        tbl[5]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,8'h05, 1'b1,3'd3,8'h01,1'b0,1'b0,1'b0,1'b0,16'h0000};
        tbl[6]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,8'h05, 1'b1,3'd4,8'h00,1'b1,1'b0,1'b0,1'b0,16'h0040};
        tbl[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00, 1'b0,3'd0,8'h00,1'b0,1'b0,1'b0,1'b0,16'h0040};
        // T4: irq 08 at start, 0A from D3 -> iack 02, vector 0048.
        tbl[8]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,8'h00, 1'b0,3'd0,8'h00,1'b0,1'b0,1'b0,1'b0,16'h0040};
        tbl[9]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,8'h08, 1'b0,3'd0,8'h00,1'b0,1'b1,1'b0,1'b0,16'h0040};
        tbl[10] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,8'h08, 1'b1,3'd0,8'h00,1'b0,1'b0,1'b0,1'b0,16'h0040};
        tbl[11] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,8'h08, 1'b1,3'd1,8'h00,1'b0,1'b0,1'b0,1'b0,16'h0040};
        tbl[12] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,8'h0A, 1'b1,3'd2,8'h00,1'b0,1'b0,1'b0,1'b0,16'h0040};
        tbl[13] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,8'h0A, 1'b1,3'd3,8'h02,1'b0,1'b0,1'b0,1'b0,16'h0040};
        tbl[14] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,8'h0A, 1'b1,3'd4,8'h00,1'b1,1'b0,1'b0,1'b0,16'h0048};
        tbl[15] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00, 1'b0,3'd0,8'h00,1'b0,1'b0,1'b0,1'b0,16'h0048};

        reset = 1'b1; mcyc_end = 1'b0; insn_end = 1'b0; op_ei = 1'b0; op_di = 1'b0;
        op_reti = 1'b0; op_halt = 1'b0; irq = 8'h00;
        cyc(1,1,1,1,0,1,0,8'hFF);
        cyc(1,0,0,0,0,0,0,8'h00);
        cyc(0,0,0,0,0,0,0,8'h00);
        chk("reset_state", dut_out(), 32'h0000_0000);
        mchk = 1'b1;

        foreach (tbl[i]) begin
            cyc(tbl[i].rs, tbl[i].me, tbl[i].ie, tbl[i].ei, tbl[i].di, tbl[i].rt, tbl[i].hl, tbl[i].iv);
            chk($sformatf("table_row%0d", i), dut_out(),
                {tbl[i].e_disp, tbl[i].e_dm, tbl[i].e_iack, tbl[i].e_vv, tbl[i].e_ime,
                 tbl[i].e_halt, tbl[i].e_bug, tbl[i].e_vec});
        end

        // T2: EI delay, irq 10 held -> dispatch starts two boundaries later.
        cyc(0,1,1,1,0,0,0,8'h10);
        cyc(0,1,1,0,0,0,0,8'h10);
        chk("ei_no_disp_n1", {31'd0, dispatch}, 32'd0);
        chk("ei_ime_late",   {31'd0, ime}, 32'd0);
        cyc(0,1,1,0,0,0,0,8'h10);
        chk("ei_ime_set",    {31'd0, ime}, 32'd1);
        cyc(0,1,0,0,0,0,0,8'h10);
        chk("ei_disp_n2",    {31'd0, dispatch}, 32'd1);
        cyc(0,1,0,0,0,0,0,8'h10);
        cyc(0,1,0,0,0,0,0,8'h10);
        cyc(0,1,0,0,0,0,0,8'h10);
        chk("ei_iack",       {24'd0, iack}, 32'h10);
        cyc(0,1,0,0,0,0,0,8'h10);
        chk("ei_vector",     {15'd0, vec_valid, vector}, {15'd0, 1'b1, 16'h0060});
        cyc(0,0,0,0,0,0,0,8'h00);

        // T3: request dropped during D2 -> no iack, vector 0.
        cyc(0,1,1,0,0,1,0,8'h00);
        cyc(0,1,1,0,0,0,0,8'h02);
        cyc(0,1,0,0,0,0,0,8'h02);
        cyc(0,1,0,0,0,0,0,8'h00);
        cyc(0,1,0,0,0,0,0,8'h00);
        cyc(0,1,0,0,0,0,0,8'h00);
        chk("drop_no_iack",  {24'd0, iack}, 32'd0);
        cyc(0,1,0,0,0,0,0,8'h00);
        chk("drop_vector",   {15'd0, vec_valid, vector}, {15'd0, 1'b1, 16'h0000});
        cyc(0,0,0,0,0,0,0,8'h00);

        // T5: HALT with ime=0, wake by irq 04, no dispatch.
        cyc(0,1,1,0,0,0,1,8'h00);
        cyc(0,0,0,0,0,0,0,8'h00);
        chk("halt_set",      {31'd0, halted}, 32'd1);
        cyc(0,0,0,0,0,0,0,8'h04);
        cyc(0,0,0,0,0,0,0,8'h04);
        chk("halt_wake",     {31'd0, halted}, 32'd0);
        cyc(0,1,1,0,0,0,0,8'h04);
        cyc(0,1,1,0,0,0,0,8'h04);
        chk("wake_no_disp",  {31'd0, dispatch}, 32'd0);
        // HALT bug: ime=0 with a request already pending.
        cyc(0,1,1,0,0,0,1,8'h04);
        cyc(0,0,0,0,0,0,0,8'h04);
        chk("halt_bug_pulse", {30'd0, halt_bug, halted}, 32'd2);
        cyc(0,0,0,0,0,0,0,8'h04);
        chk("halt_bug_end",  {31'd0, halt_bug}, 32'd0);
        // Wake with ime=1: dispatch at next mcyc_end without insn_end.
        cyc(0,1,1,0,0,1,0,8'h00);
        cyc(0,1,1,0,0,0,1,8'h00);
        cyc(0,0,0,0,0,0,0,8'h00);
        cyc(0,0,0,0,0,0,0,8'h01);
        cyc(0,1,0,0,0,0,0,8'h01);
        chk("wake_ime_pre",  {30'd0, halted, dispatch}, 32'd0);
        cyc(0,0,0,0,0,0,0,8'h01);
        chk("wake_ime_disp", {31'd0, dispatch}, 32'd1);
        for (int i = 0; i < 5; i++) cyc(0,1,0,0,0,0,0,8'h01);
        cyc(0,0,0,0,0,0,0,8'h00);

        // T6: reset in D3, and reset on the D4 sampling clk.
        cyc(0,1,1,0,0,1,0,8'h00);
        cyc(0,1,1,0,0,0,0,8'h01);
        cyc(0,1,0,0,0,0,0,8'h01);
        cyc(0,1,0,0,0,0,0,8'h01);
        cyc(1,1,0,0,0,0,0,8'h01);
        cyc(0,1,0,0,0,0,0,8'h01);
        chk("rst_d3", {dispatch, ime, iack}, 10'd0);
        cyc(0,1,1,0,0,1,0,8'h01);
        cyc(0,1,1,0,0,0,0,8'h01);
        cyc(0,1,0,0,0,0,0,8'h01);
        cyc(0,1,0,0,0,0,0,8'h01);
        cyc(0,1,0,0,0,0,0,8'h01);
        cyc(1,1,0,0,0,0,0,8'h01);
        chk("rst_d4_no_iack", {24'd0, iack}, 32'd0);
        cyc(0,0,0,0,0,0,0,8'h00);
        chk("rst_d4_idle", {30'd0, dispatch, vec_valid}, 32'd0);

        // Randomized traffic, checked every clk by the model.
        begin
            logic [7:0] iv;
            bit me, ie;
            iv = 8'h00;
            for (int c = 0; c < 3000; c++) begin
                me = (c % 4 == 3);
                ie = me && ($urandom % 2 == 0);
                if (c % 16 == 0) iv = ($urandom % 3 == 0) ? (8'($urandom) & 8'($urandom)) : 8'h00;
                cyc(($urandom % 600) == 0, me, ie,
                    ($urandom % 10) == 0, ($urandom % 12) == 0,
                    ($urandom % 12) == 0, ($urandom % 14) == 0, iv);
            end
        end

        cyc(0,0,0,0,0,0,0,8'h00);
        mchk = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
